// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Multi-stage register pipeline with valid/ready flow control, bubble
//   collapsing and a synchronous flush. It retimes long datapaths without
//   dropping samples under backpressure.
//
// Parameters
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data register on reset
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high; overrides flush and handshakes
//   flush      synchronous drop of all in-flight data
//   in_valid   upstream data valid
//   in_ready   chain can accept in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds valid data (register output)
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data register
//   occupancy  registered valid-stage count (only with PIPE_REG_OCC_EN)
//
// Build option
//   PIPE_REG_OCC_EN  adds the occupancy port and its counter.

module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // Ready chain evaluated top-down with a running "blocked" term:
  // stage i is blocked only when it and every stage after it are valid
  // and the output is stalled. Equivalent to rdy[i] = !v[i] || rdy[i+1]
  // but free of a self-referencing vector.
  always_comb begin
    logic blocked;
    blocked = !out_ready;
    rdy     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      blocked              = blocked && v[DEPTH-1-k];
      rdy[DEPTH-1-k]       = !blocked;
    end
  end

  // Upstream source of every stage.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid && !flush;
    up_d[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      // Data registers are intentionally left untouched on flush.
      v <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            d[i] <= up_d[i];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
  localparam int unsigned OCCW = $clog2(DEPTH+1);

  logic in_acc;
  logic out_acc;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (in_acc && !out_acc) begin
      occupancy <= occupancy + OCCW'(1);
    end else if (out_acc && !in_acc) begin
      occupancy <= occupancy - OCCW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 3;
  localparam logic [15:0] RV    = 16'hA5A5;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef PIPE_REG_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  pipe_reg_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered list of words in flight with the stage each sits in.
  logic [15:0] q_data [$];
  int          q_pos  [$];
  logic [15:0] last_out = RV;

  int cyc       = 0;
  int obs_deliv = 0;
  bit lat_on    = 0;
  bit seen1     = 0;
  int t_acc1    = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_update(input logic rst, input logic fl, input logic acc_in,
                              input logic [15:0] din, input logic acc_out);
    int prev;
    int np;
    if (rst) begin
      q_data.delete();
      q_pos.delete();
      last_out = RV;
    end else if (fl) begin
      q_data.delete();
      q_pos.delete();
    end else begin
      if (acc_out) begin
        void'(q_data.pop_front());
        void'(q_pos.pop_front());
      end
      // Each word advances one stage unless the word ahead still occupies it.
      prev = DEPTH;
      for (int k = 0; k < q_pos.size(); k++) begin
        np = (q_pos[k] + 1 < prev - 1) ? q_pos[k] + 1 : prev - 1;
        if (np == DEPTH - 1 && q_pos[k] != DEPTH - 1) last_out = q_data[k];
        q_pos[k] = np;
        prev     = np;
      end
      if (acc_in) begin
        q_data.push_back(din);
        q_pos.push_back(0);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic ordy,
                       input logic fl, input logic rst);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
  endtask

  task automatic step(input logic iv, input logic [15:0] id, input logic ordy,
                      input logic fl, input logic rst);
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic        acc_in;
    logic        acc_out;
    drive(iv, id, ordy, fl, rst);
    e_ov = (q_data.size() > 0) && (q_pos[0] == DEPTH - 1);
    e_od = e_ov ? q_data[0] : last_out;
    e_ir = !fl && (q_data.size() < DEPTH || ordy);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("out_data", 32'(out_data), 32'(e_od));
`ifdef PIPE_REG_OCC_EN
      chk("occupancy", 32'(occupancy), 32'(q_data.size()));
`endif
      if (out_valid === 1'b1 && ordy) obs_deliv++;
      if (lat_on && iv && e_ir && id == 16'h0001) t_acc1 = cyc;
      if (lat_on && !seen1 && out_valid === 1'b1 && out_data === 16'h0001) begin
        seen1 = 1;
        chk("latency", 32'(cyc - t_acc1), 32'(DEPTH));
      end
    end
    acc_in  = iv && e_ir && !rst;
    acc_out = e_ov && ordy && !rst;
    @(posedge clk);
    model_update(rst, fl, acc_in, id, acc_out);
    cyc++;
    #1;
  endtask

  initial begin
    logic [15:0] r;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;

    // Reset
    step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'hA5A5);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_REG_OCC_EN
    chk("rst_occupancy", 32'(occupancy), 32'd0);
`endif

    // Full-rate stream
    obs_deliv = 0;
    lat_on    = 1;
    for (int n = 1; n <= 16; n++) step(1'b1, 16'(n), 1'b1, 1'b0, 1'b0);
    lat_on = 0;
    for (int n = 0; n < 5; n++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("stream_seen_first", 32'(seen1), 32'd1);
    chk("stream_delivered", 32'(obs_deliv), 32'd16);

    // Backpressure to capacity
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_REG_OCC_EN
    chk("full_occupancy", 32'(occupancy), 32'd3);
`endif
    step(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0044, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Bubble collapse behind a stalled last stage
    step(1'b1, 16'h00AB, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    chk("bubble_last_valid", 32'(out_valid), 32'd1);
    chk("bubble_ready_55", 32'(in_ready), 32'd1);
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    chk("bubble_ready_66", 32'(in_ready), 32'd1);
    step(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0067, 1'b0, 1'b0, 1'b0);
    chk("bubble_full", 32'(in_ready), 32'd0);
    for (int n = 0; n < 5; n++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Flush with two words in flight
    step(1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0062, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_REG_OCC_EN
    chk("flush_occupancy", 32'(occupancy), 32'd0);
`endif
    for (int n = 0; n < 5; n++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes
    for (int n = 0; n < 300; n++) begin
      r = 16'($urandom);
      step(($urandom % 4) != 0, r, ($urandom % 3) != 0, ($urandom % 25) == 0, 1'b0);
    end

    // Reset mid-stream with full chain
    for (int n = 0; n < 4; n++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'hA5A5);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom);
      step(($urandom % 3) != 0, r, ($urandom % 2) != 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
